// File: rtl/rx_drain_ctrl.sv
// rx_drain_ctrl: drains the UART receiver's single-byte holding buffer into
// a small local FIFO, tagging each byte with framing-error and overrun flags.
// After each capture it acknowledges the receiver (host_ready), optionally
// clears the sticky framing error, then waits HOLDOFF cycles before sampling
// the receiver again so its buffer state has settled.
// Optional feature: define RX_ERR_COUNT_EN to build the saturating
// framing-error / overrun counters; otherwise both counter ports read 0.
// Handshake: the consumer pops the FIFO head on any cycle where out_valid and
// out_ready are both high; out_data/out_ferr/out_ovr are meaningful only
// while out_valid is high.
module rx_drain_ctrl #(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_en,
    input  logic                     flush,
    input  logic [7:0]               rx_data,
    input  logic                     rx_data_valid,
    input  logic                     framing_err,
    input  logic                     overrun,
    output logic                     host_ready,
    output logic                     clear_framing_err,
    output logic [7:0]               out_data,
    output logic                     out_ferr,
    output logic                     out_ovr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [15:0]              ferr_count,
    output logic [15:0]              ovr_count,
    input  logic                     cnt_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
    localparam logic [2:0]    HOLD_L  = 3'(HOLDOFF);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLDOFF} state_t;

    state_t          state, state_nxt;
    logic [2:0]      hold_cnt;
    logic            ack_ferr;
    logic            ovr_q, ovr_rise, ovr_pend;
    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [FW-1:0]   fill_q;
    logic            capture, push, pop;

    // A capture is only decided in IDLE and only when there is room, so the
    // FIFO can never be written while full.
    assign capture  = (state == S_IDLE) && rx_en && rx_data_valid && (fill_q < DEPTH_F);
    assign push     = capture && !flush;
    assign pop      = out_valid && out_ready && !flush;
    assign ovr_rise = overrun && !ovr_q;

    // Next-state and acknowledge outputs; outputs decode from the state so an
    // asynchronous reset removes host_ready at once.
    always_comb begin
        state_nxt         = state;
        host_ready        = 1'b0;
        clear_framing_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (capture) state_nxt = S_ACK;
            end
            S_ACK: begin
                host_ready        = 1'b1;
                clear_framing_err = ack_ferr;
                state_nxt         = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (hold_cnt == 3'd1) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Holdoff down-counter (loaded while leaving ACK) and the ferr tag of
    // the byte being acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 3'd0;
            ack_ferr <= 1'b0;
        end else begin
            if (capture) ack_ferr <= framing_err;
            if (state == S_ACK)
                hold_cnt <= HOLD_L;
            else if (state == S_HOLDOFF && hold_cnt != 3'd1)
                hold_cnt <= hold_cnt - 3'd1;
        end
    end

    // Overrun edge detect and pending-overrun flag; a new edge beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q    <= 1'b0;
            ovr_pend <= 1'b0;
        end else begin
            ovr_q <= overrun;
            if (ovr_rise)              ovr_pend <= 1'b1;
            else if (capture || flush) ovr_pend <= 1'b0;
        end
    end

    // Circular FIFO storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 10'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {ovr_pend, framing_err, rx_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    assign {out_ovr, out_ferr, out_data} = mem[rd_ptr];
    assign out_valid = (fill_q != '0);
    assign fill      = fill_q;

`ifdef RX_ERR_COUNT_EN
    logic [15:0] ferr_q, ovr_cnt_q;

    // Saturating error counters; clear takes priority over an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ferr_q    <= 16'd0;
            ovr_cnt_q <= 16'd0;
        end else if (cnt_clear) begin
            ferr_q    <= 16'd0;
            ovr_cnt_q <= 16'd0;
        end else begin
            if (capture && framing_err && ferr_q != 16'hFFFF) ferr_q <= ferr_q + 16'd1;
            if (ovr_rise && ovr_cnt_q != 16'hFFFF) ovr_cnt_q <= ovr_cnt_q + 16'd1;
        end
    end

    assign ferr_count = ferr_q;
    assign ovr_count  = ovr_cnt_q;
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear = cnt_clear;
    assign ferr_count = 16'd0;
    assign ovr_count  = 16'd0;
`endif

endmodule

// File: doc/rx_drain_ctrl.md
# rx_drain_ctrl

Receive-side controller that sequences the UART receiver's single-byte holding buffer. It watches the receiver's data-valid, framing-error and overrun outputs, captures each byte with its error tags into a small local FIFO, and acknowledges the receiver with host_ready. It also clears the receiver's sticky framing error and paces acknowledgements so the receiver's buffer state settles before the next capture. It sits between the receiver and the bus or host-side consumer.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- HOLDOFF, 2: cycles waited after each acknowledge before the receiver is sampled again; 1..7.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset. One clock; no other reset.
- rx_en  in  1  capture enable; when low, no new captures start.
- flush  in  1  synchronous FIFO empty, single-cycle pulse.
- rx_data  in  8  receiver data.
- rx_data_valid  in  1  receiver buffer holds a byte.
- framing_err  in  1  receiver sticky framing error.
- overrun  in  1  receiver overrun level.
- host_ready  out  1  one-cycle acknowledge to the receiver.
- clear_framing_err  out  1  one-cycle clear to the receiver.
- out_data  out  8  FIFO head byte.
- out_ferr  out  1  head byte was captured while framing_err was high.
- out_ovr  out  1  an overrun occurred before this byte.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer pops the head when it is high together with out_valid.
- fill  out  $clog2(DEPTH)+1  FIFO occupancy.
- ferr_count  out  16  framing-error counter (see Configuration).
- ovr_count  out  16  overrun counter (see Configuration).
- cnt_clear  in  1  zeroes both counters.

## Operation
- The controller FSM has three states: IDLE, ACK and HOLDOFF.
- **IDLE:**
  - A capture starts when rx_en, rx_data_valid and fill<DEPTH are all true.
  - On that cycle, the entry {ovr_pend, framing_err, rx_data} is pushed. The FSM then moves to ACK.
  - Otherwise the FSM stays in IDLE.
- **ACK:**
  - host_ready=1 for exactly one cycle.
  - clear_framing_err=1 on the same cycle if the entry just pushed had ferr=1.
  - Next state is HOLDOFF.
- **HOLDOFF:**
  - A down-counter loads HOLDOFF on entry.
  - The FSM returns to IDLE when the counter reaches 1.
  - rx_data_valid is ignored throughout HOLDOFF.
- **ovr_pend:**
  - Set on a rising edge of overrun, with 1-cycle registered edge detect.
  - Cleared when it is tagged into a pushed entry.
  - If the set and the clear fall on the same cycle, set wins.
- **FIFO:**
  - Circular buffer with read/write pointers that wrap modulo DEPTH.
  - Push and pop on the same cycle are allowed at any fill; fill is unchanged.
  - Pop when empty is ignored.
  - A push is never attempted when full, because of the IDLE gate. The receiver therefore back-pressures and eventually raises overrun.
- **flush:**
  - Empties the FIFO and clears ovr_pend.
  - Does not change FSM state. An entry pushed on the flush cycle is discarded.
- **rx_en deasserted mid-sequence:** ACK and HOLDOFF complete normally.
- **Outputs:** out_data, out_ferr and out_ovr are driven from the head entry and are don't-care when out_valid=0.

## Timing
- **Reset values:**
  - FSM=IDLE.
  - host_ready=0, clear_framing_err=0.
  - out_valid=0, fill=0.
  - ovr_pend=0, overrun edge register=0.
  - Counters=0.
  - out_data/out_ferr/out_ovr=0.
- **Capture latency:**
  - Capture decided in cycle t.
  - out_valid=1 and fill incremented from cycle t+1.
  - host_ready=1 in cycle t+1.
- **Next sample:** the earliest next capture decision is cycle t+2+HOLDOFF.
- **Throughput:** at most one byte per 2+HOLDOFF cycles.
- **Reset mid-operation:** an asynchronous return to the reset values above, with any held host_ready removed immediately.

## Configuration
- RX_ERR_COUNT_EN defined:
  - ferr_count increments, saturating at 16'hFFFF, on every pushed entry with ferr=1.
  - ovr_count increments, saturating, on every overrun rising edge.
  - cnt_clear zeroes both counters; on the same cycle it takes priority over an increment.
- Undefined:
  - Both counter ports are constant 0.
  - cnt_clear is ignored and no counter flops exist.

## Test plan
- **Single byte:** receiver presents 8'hA5 with framing_err=0 at t, FIFO empty.
  - host_ready pulses at t+1; out_valid=1 with out_data=A5, ferr=0, ovr=0 at t+1.
  - No second capture before t+2+HOLDOFF.
- **Framing error:** present 8'h3C with framing_err=1.
  - Entry has ferr=1; clear_framing_err and host_ready are high together for one cycle.
  - ferr_count=1 with RX_ERR_COUNT_EN, 0 without.
- **Fill and overrun:** out_ready=0, push DEPTH bytes 01..04.
  - fill=4 and no further host_ready.
  - Raise overrun, then pop once: the next captured byte has ovr=1; ovr_count=1.
- **Simultaneous push/pop:** fill=2 with out_ready=1 during a capture cycle.
  - fill stays 2 and order is preserved (FIFO order verified across wrap).
- **Flush and reset:**
  - flush at fill=3 gives fill=0 and out_valid=0 next cycle; the FSM continues its sequence.
  - Asserting rst during ACK drops host_ready in the same cycle, and all outputs read their reset values.
